slow_access_timer: RTL and testbench
====================================

// Module: slow_access_timer
// PURPOSE
//  Consumer of the slow-mode settings register. Watches bus cycles to slow I/O devices; when an
//  access hits a device whose Slow* enable is set, requests slow CPU speed and keeps requesting it
//  for SlowTimeout prescaled ticks after the access ends. Sits between the settings register,
//  the address decode chip selects and the clock-switch logic.
// PARAMETERS
//  PRESCALE  1024  CLK cycles per timeout tick; must be >= 2; prescaler width = $clog2(PRESCALE)
// PORTS
//  CLK            in   1  system clock, all state on rising edge
//  nPOR           in   1  reset; one clock; reset is asynchronous and active-low
//  BACT           in   1  bus cycle active (synchronous to CLK)
//  IACKCS         in   1  interrupt-acknowledge cycle select
//  VIACS          in   1  VIA select
//  IWMCS          in   1  IWM select
//  SCCCS          in   1  SCC select
//  SCSICS         in   1  SCSI select
//  SndCSWR        in   1  sound/PWM buffer write select
//  SlowIACK..SlowSnd in 1 each  per-device slow enables (one port per CS above, same order)
//  SlowClockGate  in   1  settings bit: allow clock gating while slow
//  SlowTimeout    in   4  hold-off length in ticks; 0 = access only, F = hold indefinitely
//  SlowReq        out  1  registered slow-speed request to clock switch
//  SlowGate       out  1  registered: SlowReq && SlowClockGate
// BEHAVIOUR
//  - Hit = BACT & OR of (CS_x & Slow_x) over the six device pairs; combinational, internal only.
//  - Reset (async, nPOR=0): state IDLE, SlowReq=0, SlowGate=0, tick counter=0, prescaler=0.
//  - States: IDLE, ACCESS, COUNT, HOLD. SlowReq=1 in ACCESS/COUNT/HOLD, 0 in IDLE.
//  - Any state, Hit=1 -> ACCESS next edge; counter <= SlowTimeout, prescaler <= 0. Hit beats tick.
//  - ACCESS, Hit=0: SlowTimeout==0 -> IDLE; ==F -> HOLD; else -> COUNT (counter keeps loaded value).
//  - COUNT: prescaler increments each CLK; at PRESCALE-1 it wraps to 0 and issues tick.
//    tick with counter==1 -> IDLE; tick otherwise -> counter-1. Counter never underflows.
//  - HOLD: stays while SlowTimeout==F; if SlowTimeout changes to 1..E -> COUNT, counter <= new
//    value, prescaler <= 0; if changes to 0 -> IDLE.
//  - SlowTimeout/Slow_x changes during COUNT do not reload or cancel; they apply on next Hit.
//  - Latency: SlowReq rises on the first CLK edge with Hit=1 (1 cycle); falls on the edge that
//    consumes the final tick, or the edge after Hit drops when SlowTimeout==0.
//  - SlowGate registered from next-state SlowReq and current SlowClockGate; same edges as SlowReq.
//  - Prescaler held at 0 outside COUNT; first tick in COUNT is exactly PRESCALE cycles after entry.
//  - Hit during COUNT restarts full timeout (retrigger), no partial-tick carryover.
// STRUCTURE
//  - Shared package/include: state encoding (2 bits), SLOW_TO_NONE=4'h0, SLOW_TO_HOLD=4'hF.
//  - One sub-module: slow_tick_div (parameter PRESCALE; inputs CLK, nPOR, en, clr; output tick).
//  - Top holds Hit decode, FSM, 4-bit tick counter, output registers.
// TESTING  (bench uses PRESCALE=4)
//  - Reset: nPOR low mid-COUNT -> SlowReq/SlowGate drop immediately, state IDLE, no glitch on release.
//  - VIACS+BACT 1 cycle, SlowVIA=1, SlowTimeout=3 -> SlowReq high next edge, low 12 cycles after Hit ends.
//  - IWMCS+BACT, SlowIWM=0, all other enables 1 -> SlowReq stays 0.
//  - SlowTimeout=0, SCCCS+BACT 3 cycles -> SlowReq high 3 cycles exactly, then IDLE.
//  - SlowTimeout=2, second Hit at cycle 6 of COUNT -> timeout restarts; SlowReq low 8 cycles after second Hit.
//  - SlowTimeout=F, Hit then wait 100 cycles -> SlowReq held; set SlowTimeout=1 -> low 4 cycles later;
//    SlowClockGate=0 throughout -> SlowGate never asserts.

Source files
------------

// File: rtl/slow_access_timer_pkg.sv
// Shared definitions for the slow-access timer: FSM state encoding and the
// special SlowTimeout codes.
package slow_access_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_COUNT  = 2'd2,
        ST_HOLD   = 2'd3
    } slowState_t;

    localparam logic [3:0] SLOW_TO_NONE = 4'h0;
    localparam logic [3:0] SLOW_TO_HOLD = 4'hF;

endpackage

// File: rtl/slow_tick_div.sv
// Timeout prescaler: counts CLK cycles while enabled and issues a one-cycle
// tick on the cycle it wraps from PRESCALE-1 back to 0.
module slow_tick_div #(
    parameter int PRESCALE = 1024
) (
    input  logic CLK,
    input  logic nPOR,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] preCnt;

    assign tick = en && !clr && (preCnt == LAST);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            preCnt <= '0;
        end else if (clr) begin
            preCnt <= '0;
        end else if (en) begin
            preCnt <= tick ? '0 : preCnt + W'(1);
        end
    end

endmodule

// File: rtl/slow_access_timer.sv
// Requests slow CPU speed on accesses to slow-enabled I/O devices and holds
// the request for SlowTimeout prescaled ticks after the access ends.
module slow_access_timer
    import slow_access_timer_pkg::*;
#(
    parameter int PRESCALE = 1024
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCSWR,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowReq,
    output logic       SlowGate
);

    slowState_t state, stateNxt;
    logic [3:0] tickCnt, tickCntNxt;
    logic       hit, tick, reqNxt;

    assign hit = BACT & |{IACKCS  & SlowIACK,
                          VIACS   & SlowVIA,
                          IWMCS   & SlowIWM,
                          SCCCS   & SlowSCC,
                          SCSICS  & SlowSCSI,
                          SndCSWR & SlowSnd};

    // Prescaler only runs in COUNT; a retriggering hit discards any partial tick.
    slow_tick_div #(.PRESCALE(PRESCALE)) tickDiv (
        .CLK  (CLK),
        .nPOR (nPOR),
        .en   (state == ST_COUNT),
        .clr  (hit || (state != ST_COUNT)),
        .tick (tick)
    );

    always_comb begin
        stateNxt   = state;
        tickCntNxt = tickCnt;
        if (hit) begin
            stateNxt   = ST_ACCESS;
            tickCntNxt = SlowTimeout;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ACCESS: begin
                    if (SlowTimeout == SLOW_TO_NONE)      stateNxt = ST_IDLE;
                    else if (SlowTimeout == SLOW_TO_HOLD) stateNxt = ST_HOLD;
                    else                                  stateNxt = ST_COUNT;
                end
                ST_COUNT: begin
                    // Counter may hold 0 if SlowTimeout moved during ACCESS; treat as final tick.
                    if (tick) begin
                        if (tickCnt <= 4'd1) begin
                            stateNxt   = ST_IDLE;
                            tickCntNxt = '0;
                        end else begin
                            tickCntNxt = tickCnt - 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (SlowTimeout == SLOW_TO_NONE) begin
                        stateNxt = ST_IDLE;
                    end else if (SlowTimeout != SLOW_TO_HOLD) begin
                        stateNxt   = ST_COUNT;
                        tickCntNxt = SlowTimeout;
                    end
                end
                default: stateNxt = ST_IDLE;
            endcase
        end
    end

    assign reqNxt = (stateNxt != ST_IDLE);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state    <= ST_IDLE;
            tickCnt  <= '0;
            SlowReq  <= 1'b0;
            SlowGate <= 1'b0;
        end else begin
            state    <= stateNxt;
            tickCnt  <= tickCntNxt;
            SlowReq  <= reqNxt;
            SlowGate <= reqNxt && SlowClockGate;
        end
    end

endmodule

// File: tb/tb_slow_access_timer.sv
// Scoreboard bench for slow_access_timer: a deadline-based reference model
// predicts SlowReq/SlowGate after every edge; a monitor compares each cycle.
module tb_slow_access_timer;

    localparam int P = 4;

    logic       CLK = 1'b0;
    logic       nPOR = 1'b0;
    logic       BACT = 1'b0;
    logic [5:0] cs = '0;   // [0]IACK [1]VIA [2]IWM [3]SCC [4]SCSI [5]Snd
    logic [5:0] en = '0;
    logic       SlowClockGate = 1'b0;
    logic [3:0] SlowTimeout = 4'h0;
    logic       SlowReq, SlowGate;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic req;
        logic gate;
    } exp_t;
    exp_t sbq[$];

    slow_access_timer #(.PRESCALE(P)) dut (
        .CLK           (CLK),
        .nPOR          (nPOR),
        .BACT          (BACT),
        .IACKCS        (cs[0]),
        .VIACS         (cs[1]),
        .IWMCS         (cs[2]),
        .SCCCS         (cs[3]),
        .SCSICS        (cs[4]),
        .SndCSWR       (cs[5]),
        .SlowIACK      (en[0]),
        .SlowVIA       (en[1]),
        .SlowIWM       (en[2]),
        .SlowSCC       (en[3]),
        .SlowSCSI      (en[4]),
        .SlowSnd       (en[5]),
        .SlowClockGate (SlowClockGate),
        .SlowTimeout   (SlowTimeout),
        .SlowReq       (SlowReq),
        .SlowGate      (SlowGate)
    );

    always #5 CLK = ~CLK;

    // Reference model: request is either idle, following an access, ending at a
    // known edge number, or held indefinitely.
    int     mode = 0;   // 0 idle, 1 access, 2 timed release, 3 hold
    int     loaded = 0;
    longint edgeN = 0;
    longint releaseEdge = 0;

    always @(posedge CLK) begin
        exp_t e;
        edgeN++;
        if (!nPOR) begin
            mode = 0;
        end else if (BACT && ((cs & en) != 6'd0)) begin
            mode = 1;
            loaded = int'(SlowTimeout);
        end else begin
            case (mode)
                1: begin
                    if (SlowTimeout == 4'h0)      mode = 0;
                    else if (SlowTimeout == 4'hF) mode = 3;
                    else begin
                        mode = 2;
                        releaseEdge = edgeN + P * ((loaded < 1) ? 1 : loaded);
                    end
                end
                2: if (edgeN == releaseEdge) mode = 0;
                3: begin
                    if (SlowTimeout == 4'h0) mode = 0;
                    else if (SlowTimeout != 4'hF) begin
                        mode = 2;
                        releaseEdge = edgeN + P * int'(SlowTimeout);
                    end
                end
                default: ;
            endcase
        end
        e.req  = (mode != 0);
        e.gate = (mode != 0) && SlowClockGate;
        sbq.push_back(e);
    end

    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty edge=%0d", edgeN);
        end else begin
            e = sbq.pop_front();
            if (SlowReq !== e.req) begin
                failures++;
                $display("FAIL SlowReq edge=%0d got=%b exp=%b", edgeN, SlowReq, e.req);
            end
            checks++;
            if (SlowGate !== e.gate) begin
                failures++;
                $display("FAIL SlowGate edge=%0d got=%b exp=%b", edgeN, SlowGate, e.gate);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic access(input int dev, input int n);
        BACT = 1'b1;
        cs   = 6'(1 << dev);
        cycles(n);
        BACT = 1'b0;
        cs   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d", edgeN);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nPOR = 1'b0;
        cycles(3);
        nPOR = 1'b1;
        cycles(2);

        // VIA single-cycle access, timeout 3
        en = 6'b000010; SlowTimeout = 4'd3; SlowClockGate = 1'b1;
        access(1, 1);
        cycles(20);

        // IWM not slow-enabled while all others are
        en = 6'b111011;
        access(2, 3);
        cycles(6);

        // Timeout 0: request only for the access itself
        en = 6'b111111; SlowTimeout = 4'd0;
        access(3, 3);
        cycles(6);

        // Retrigger during COUNT
        SlowTimeout = 4'd2;
        access(3, 1);
        cycles(7);
        access(4, 1);
        cycles(14);

        // Indefinite hold, then released by a finite timeout
        SlowTimeout = 4'hF; SlowClockGate = 1'b0;
        access(5, 1);
        cycles(100);
        SlowTimeout = 4'd1;
        cycles(8);

        // Async reset in the middle of COUNT
        SlowTimeout = 4'd5; SlowClockGate = 1'b1;
        access(1, 1);
        cycles(6);
        #2 nPOR = 1'b0;
        #1;
        checks++;
        if (SlowReq !== 1'b0 || SlowGate !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%b%b exp=00", SlowReq, SlowGate);
        end
        @(negedge CLK);
        nPOR = 1'b1;
        cycles(4);

        // Randomized bursts
        for (int b = 0; b < 80; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: SlowTimeout = 4'h0;
                    1: SlowTimeout = 4'hF;
                    default: SlowTimeout = 4'($urandom_range(1, 4));
                endcase
            end
            SlowClockGate = 1'($urandom);
            en = 6'($urandom);
            cycles($urandom_range(0, 30));
            BACT = 1'($urandom_range(0, 4) != 0);
            cs   = 6'($urandom);
            cycles($urandom_range(1, 3));
            BACT = 1'b0;
            cs   = '0;
        end
        SlowTimeout = 4'd1;
        cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
